// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - b_in, one bit per clock through a single borrow flop.
// Define SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] sh_d;

  // Operands shift right each RUN edge, so bit 0 always holds the bit being processed.
  assign d_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign sh_d  = {d_bit, sh_q[WIDTH-1:1]};

`ifdef SUB_OVF_EN
  logic ovf_q;
  logic ovf_d;
  // On the last edge a_q[0]/b_q[0] are the original sign bits and d_bit is the result sign.
  assign ovf_d = (a_q[0] ^ b_q[0]) & (d_bit ^ a_q[0]);
  assign ovf   = ovf_q;
`else
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= b_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            diff_q  <= sh_d;
            bout_q  <= br_d;
`ifdef SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle bit-serial N-bit subtractor computing diff = a - b - b_in, one bit per clock via a single registered borrow. It is the inverse-direction companion to the ripple full-adder chain, built for area-constrained datapaths where a WIDTH-deep combinational borrow chain is not wanted. It uses a start/busy/done handshake and holds its result until the next operation completes.

Parameters:
WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; operands sampled on the edge where start=1 and the block is accepting
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
b_in  input  1  borrow in
busy  output  1  high while bits are being processed (RUN state)
done  output  1  one-cycle pulse; diff/b_out/ovf valid from this cycle onward
diff  output  WIDTH  result a - b - b_in, modulo 2^WIDTH
b_out  output  1  borrow out; 1 when unsigned a < b + b_in
ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE; busy=0; done=0; diff=0; b_out=0; ovf=0; internal operand, shift and borrow registers and bit counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> latch a, b; borrow reg <= b_in; counter <= 0; go to RUN.
- RUN: busy=1. Each edge processes bit i = counter:
  - d = a[i] ^ b[i] ^ br
  - br <= (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
  - d is shifted into the internal result register, LSB first.
  - When counter = WIDTH-1, that edge also loads diff <= full result and b_out <= final borrow, then goes to DONE with done=1.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 -> accepted exactly as in IDLE (back-to-back); next state RUN.
  - otherwise -> IDLE.
- Latency: if start is sampled at edge E0, bits are processed at edges E1..E(WIDTH). done is high in the cycle after edge E(WIDTH). Throughput is one result per WIDTH+1 cycles.
- start while in RUN is ignored: no operand relatch, no restart.
- a, b and b_in may change freely after the accepting edge; only the latched copies are used.
- diff, b_out and ovf change only on the completion edge. They hold the previous result throughout IDLE and RUN.
- rst asserted mid-operation aborts immediately to the reset values. No done is produced for the aborted operation.
- Wrap-around: diff is always modulo 2^WIDTH, e.g. 0 - 0 - 1 = all ones with b_out=1.

Optional Feature:
Macro SUB_OVF_EN.
- Defined: ovf is registered on the completion edge as (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]), using the latched operands. It holds like diff and resets to 0.
- Not defined: ovf is tied to constant 0 and no overflow logic is built. The port list is unchanged.

Test Plan:
- WIDTH=4, a=9, b=3, b_in=0, start pulse at E0 -> busy high for 4 cycles; done pulse after E4; diff=6, b_out=0, ovf=0.
- a=3, b=9, b_in=0 -> diff=0xA, b_out=1; diff/b_out stay 6/0 during RUN until completion.
- a=0, b=0, b_in=1 -> diff=0xF, b_out=1. Then a=0xF, b=0xF, b_in=0 -> diff=0, b_out=0.
- Overflow case, a=7, b=0xF (-1), b_in=0 -> diff=8, b_out=1:
  - with SUB_OVF_EN: ovf=1; a=5, b=2 then gives ovf=0.
  - without SUB_OVF_EN: ovf=0 throughout.
- Handshake:
  - start held high during RUN with changing a/b -> result uses operands from E0 only.
  - start=1 in the DONE cycle with a=8, b=1 -> next op accepted with no IDLE cycle; second done after 5 more edges with diff=7.
- rst pulsed asynchronously (not clock-aligned) at mid-RUN of a=9, b=3 -> all outputs 0 immediately, state IDLE, no done. A following start with a=2, b=1 completes normally with diff=1.
